// File: rtl/csi_box_binner_if.sv
// csi_box_binner_if -- signal bundle between a CSI-2 style pixel source and
// the box binner.
//
// Handshake: the input side has no back-pressure. A word on pixel_data is
// consumed when data_enable, in_line and in_frame are all high in the same
// cycle. The output side is a one-cycle strobe: out_x/out_y/out_data are
// meaningful only while out_valid is high, and the sink must take them in
// that cycle. frame_done is an independent one-cycle pulse; frame_count is a
// level that is always valid.
//
// Signals:
//   in_frame     frame envelope
//   in_line      line payload envelope
//   pixel_data   four RAW8 pixels, bits 7:0 leftmost
//   data_enable  pixel_data qualifier
//   out_valid    output strobe
//   out_x        output column
//   out_y        output row
//   out_data     box-averaged pixel
//   frame_done   end-of-frame pulse
//   frame_count  completed frames, modulo 2^16
//
// Modports: master = pixel source / output sink, slave = the binner.
interface csi_box_binner_if;
   logic        in_frame;
   logic        in_line;
   logic [31:0] pixel_data;
   logic        data_enable;
   logic        out_valid;
   logic [5:0]  out_x;
   logic [4:0]  out_y;
   logic [7:0]  out_data;
   logic        frame_done;
   logic [15:0] frame_count;

   modport master (
      output in_frame, in_line, pixel_data, data_enable,
      input  out_valid, out_x, out_y, out_data, frame_done, frame_count
   );

   modport slave (
      input  in_frame, in_line, pixel_data, data_enable,
      output out_valid, out_x, out_y, out_data, frame_done, frame_count
   );
endinterface

// File: rtl/csi_box_binner.sv
// csi_box_binner -- averages 2^H_SHIFT x 2^V_SHIFT boxes of a RAW8 frame
// arriving four pixels per word.
//
// Each accepted word's four bytes are summed into a horizontal accumulator.
// Every 2^(H_SHIFT-2) words a bin completes: its sum is written (first line
// of a vertical band) or added (later band lines) into a per-column store.
// On the last line of a band the completed box total, shifted down by
// H_SHIFT+V_SHIFT, is emitted one cycle after the completing word.
//
// Ports:
//   pixel_clock  sole clock, rising edge
//   reset        synchronous, active-high
//   bus          csi_box_binner_if.slave (pixel input, strobe output,
//                frame_done / frame_count)
module csi_box_binner #(
   parameter int H_SHIFT = 3,   // log2 bin width in pixels, 2..5
   parameter int V_SHIFT = 3,   // log2 bin height in lines, 0..4
   parameter int OUT_W   = 64,  // kept output columns, <= 64
   parameter int OUT_H   = 32   // kept output rows, <= 32
) (
   input logic              pixel_clock,
   input logic              reset,
   csi_box_binner_if.slave  bus
);

   localparam int HW        = 8 + H_SHIFT;        // horizontal bin sum width
   localparam int SW        = HW + V_SHIFT;       // box sum width
   localparam int WPB       = 1 << (H_SHIFT - 2); // words per bin
   localparam int BAND_LAST = (1 << V_SHIFT) - 1;

   // Edge detectors and datapath state
   logic          frame_q;
   logic          line_act_q;
   logic [HW-1:0] hacc;
   logic [3:0]    wcnt;
   // x/y counters carry one extra bit and stop one past the last real
   // index, so a saturated counter can never alias a kept column or row.
   logic [6:0]    x_cnt;
   logic [5:0]    y_cnt;
   logic [3:0]    band;

   logic [SW-1:0] col_mem [OUT_W];

   // Registered outputs
   logic          out_valid_r;
   logic [5:0]    out_x_r;
   logic [4:0]    out_y_r;
   logic [7:0]    out_data_r;
   logic          frame_done_r;
   logic [15:0]   frame_count_r;

   // A line is live only while both envelopes are high, so a frame that
   // drops with in_line still high ends the line exactly once.
   logic line_act;
   logic frame_rise;
   logic frame_fall;
   logic line_end;
   logic accept;
   logic take;

   assign line_act   = bus.in_line & bus.in_frame;
   assign frame_rise = bus.in_frame & ~frame_q;
   assign frame_fall = ~bus.in_frame & frame_q;
   assign line_end   = line_act_q & ~line_act;
   assign accept     = bus.data_enable & line_act;
   // The frame-start cycle only clears state; a word there is not binned.
   assign take       = accept & ~frame_rise;

   logic [9:0]    word_sum;
   logic [HW-1:0] bin_sum;
   logic          bin_done;
   logic          col_keep;
   logic          row_keep;
   logic          band_first;
   logic          band_last;
   logic [5:0]    col_idx;
   logic [SW-1:0] stored;
   logic [SW-1:0] band_total;
   logic [7:0]    avg;
   logic          col_wr;

   assign word_sum   = 10'(bus.pixel_data[7:0])   + 10'(bus.pixel_data[15:8]) +
                       10'(bus.pixel_data[23:16]) + 10'(bus.pixel_data[31:24]);
   assign bin_sum    = hacc + HW'(word_sum);
   assign bin_done   = (wcnt == 4'(WPB - 1));
   assign col_keep   = (x_cnt < 7'(OUT_W));
   assign row_keep   = (y_cnt < 6'(OUT_H));
   assign band_first = (band == 4'd0);
   assign band_last  = (band == 4'(BAND_LAST));
   assign col_idx    = x_cnt[5:0];
   assign stored     = col_mem[col_idx];
   // First band line ignores the stale store, which is why it needs no reset.
   assign band_total = band_first ? SW'(bin_sum) : stored + SW'(bin_sum);
   assign avg        = 8'(band_total >> (H_SHIFT + V_SHIFT));
   assign col_wr     = ~reset & take & bin_done & col_keep & row_keep;

   always_ff @(posedge pixel_clock) begin
      if (col_wr) begin
         col_mem[col_idx] <= band_total;
      end
   end

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         frame_q       <= 1'b0;
         line_act_q    <= 1'b0;
         hacc          <= '0;
         wcnt          <= '0;
         x_cnt         <= '0;
         y_cnt         <= '0;
         band          <= '0;
         out_valid_r   <= 1'b0;
         out_x_r       <= '0;
         out_y_r       <= '0;
         out_data_r    <= '0;
         frame_done_r  <= 1'b0;
         frame_count_r <= '0;
      end else begin
         frame_q      <= bus.in_frame;
         line_act_q   <= line_act;
         out_valid_r  <= 1'b0;
         frame_done_r <= frame_fall;
         if (frame_fall) begin
            frame_count_r <= frame_count_r + 16'd1;
         end

         if (frame_rise) begin
            hacc  <= '0;
            wcnt  <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
            band  <= '0;
         end else if (line_end) begin
            hacc  <= '0;
            wcnt  <= '0;
            x_cnt <= '0;
            if (band_last) begin
               band <= '0;
               if (y_cnt != 6'd32) begin
                  y_cnt <= y_cnt + 6'd1;
               end
            end else begin
               band <= band + 4'd1;
            end
         end else if (take) begin
            if (bin_done) begin
               // Completion and restart in the same cycle: nothing is lost.
               hacc <= '0;
               wcnt <= '0;
               if (x_cnt != 7'd64) begin
                  x_cnt <= x_cnt + 7'd1;
               end
               if (col_keep && row_keep && band_last) begin
                  out_valid_r <= 1'b1;
                  out_x_r     <= x_cnt[5:0];
                  out_y_r     <= y_cnt[4:0];
                  out_data_r  <= avg;
               end
            end else begin
               hacc <= bin_sum;
               wcnt <= wcnt + 4'd1;
            end
         end
      end
   end

   assign bus.out_valid   = out_valid_r;
   assign bus.out_x       = out_x_r;
   assign bus.out_y       = out_y_r;
   assign bus.out_data    = out_data_r;
   assign bus.frame_done  = frame_done_r;
   assign bus.frame_count = frame_count_r;

endmodule

// File: tb/tb_csi_box_binner.sv
// tb_csi_box_binner -- two binners (default 8x8 boxes, and 4x1 boxes) fed
// the same pixel stream; each has its own line-level reference model and
// expected queues, checked by a free-running monitor.
module tb_csi_box_binner;

   localparam int HA = 3, VA = 3;   // dut_a geometry
   localparam int HB = 2, VB = 0;   // dut_b geometry

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   csi_box_binner_if bus_a ();
   csi_box_binner_if bus_b ();

   assign bus_b.in_frame    = bus_a.in_frame;
   assign bus_b.in_line     = bus_a.in_line;
   assign bus_b.pixel_data  = bus_a.pixel_data;
   assign bus_b.data_enable = bus_a.data_enable;

   csi_box_binner dut_a (
      .pixel_clock (clk),
      .reset       (reset),
      .bus         (bus_a)
   );

   csi_box_binner #(.H_SHIFT(HB), .V_SHIFT(VB)) dut_b (
      .pixel_clock (clk),
      .reset       (reset),
      .bus         (bus_b)
   );

   int checks   = 0;
   int failures = 0;

   // {cycle[31:0], y[4:0], x[5:0], data[7:0]}
   logic [50:0] exp_q_a[$];
   logic [50:0] exp_q_b[$];
   // {cycle[31:0], frame_count[15:0]}
   logic [47:0] fd_q_a[$];
   logic [47:0] fd_q_b[$];

   logic [7:0] line_px[$];
   int         word_cyc[$];
   int         col_sum[2][64];
   int         lidx[2];
   int         fc;
   bit         cur_frame;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: one finished line of accepted pixels -> box outputs.
   task automatic model_line(input int d, input int h, input int v);
      int nb, band, row, s, bw;
      logic [50:0] e;
      bw   = 1 << h;
      nb   = line_px.size() >> h;
      band = lidx[d] % (1 << v);
      row  = lidx[d] >> v;
      for (int b = 0; b < nb; b++) begin
         if (b < 64 && row < 32) begin
            s = 0;
            for (int i = 0; i < bw; i++) s += int'(line_px[b*bw + i]);
            if (band == 0) col_sum[d][b] = s;
            else           col_sum[d][b] += s;
            if (band == (1 << v) - 1) begin
               e = {32'(word_cyc[((b + 1) << (h - 2)) - 1]), 5'(row), 6'(b),
                    8'(col_sum[d][b] >> (h + v))};
               if (d == 0) exp_q_a.push_back(e);
               else        exp_q_b.push_back(e);
            end
         end
      end
      lidx[d]++;
   endtask

   function automatic logic [31:0] make_word(input int mode, input int w);
      logic [31:0] r;
      r = '0;
      case (mode)
         0: r = 32'h80808080;
         1: for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((4*w + i) % 256);
         2: r = $urandom;
         3: r = 32'h40302010;
         default: r = 32'hFFFFFFFF;
      endcase
      return r;
   endfunction

   task automatic drive(input bit f, input bit l, input bit de, input logic [31:0] pd);
      @(posedge clk);
      #1;
      bus_a.in_frame    = f;
      bus_a.in_line     = l;
      bus_a.data_enable = de;
      bus_a.pixel_data  = pd;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(cur_frame, 1'b0, 1'($urandom_range(0, 1)), $urandom);
   endtask

   task automatic push_frame_done();
      fc++;
      fd_q_a.push_back({32'(cyc + 1), 16'(fc)});
      fd_q_b.push_back({32'(cyc + 1), 16'(fc)});
   endtask

   task automatic frame_start();
      cur_frame = 1'b1;
      lidx[0] = 0;
      lidx[1] = 0;
      idle(3);
   endtask

   task automatic frame_end();
      cur_frame = 1'b0;
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
      push_frame_done();
      idle(2);
   endtask

   // Plans the whole line first so expectations exist before any strobe.
   task automatic send_line(input int words, input int mode, input int gap, input bit end_frame);
      logic [31:0] wq[$];
      bit          de_plan[$];
      logic [31:0] w;
      int          c0, n, step;
      line_px.delete();
      word_cyc.delete();
      c0 = cyc; n = 0; step = 0;
      while (n < words) begin
         if ($urandom_range(0, 99) < gap) begin
            de_plan.push_back(1'b0);
         end else begin
            w = make_word(mode, n);
            wq.push_back(w);
            de_plan.push_back(1'b1);
            for (int i = 0; i < 4; i++) line_px.push_back(w[8*i +: 8]);
            word_cyc.push_back(c0 + 2 + step);
            n++;
         end
         step++;
      end
      model_line(0, HA, VA);
      model_line(1, HB, VB);
      n = 0;
      foreach (de_plan[k]) begin
         if (de_plan[k]) begin
            drive(1'b1, 1'b1, 1'b1, wq[n]);
            n++;
         end else begin
            drive(1'b1, 1'b1, 1'b0, $urandom);
         end
      end
      // Closing cycle carries an enabled junk word that must be ignored.
      if (end_frame) begin
         cur_frame = 1'b0;
         drive(1'b0, 1'b1, 1'b1, $urandom);
         push_frame_done();
         drive(1'b0, 1'b0, 1'b0, $urandom);
      end else begin
         drive(1'b1, 1'b0, 1'b1, $urandom);
      end
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_exp_a_left"}, exp_q_a.size(), 0);
      check({tag, "_exp_b_left"}, exp_q_b.size(), 0);
      check({tag, "_fd_a_left"}, fd_q_a.size(), 0);
      check({tag, "_fd_b_left"}, fd_q_b.size(), 0);
   endtask

   task automatic do_reset();
      cur_frame = 1'b0;
      @(posedge clk);
      #1;
      reset             = 1'b1;
      bus_a.in_frame    = 1'b0;
      bus_a.in_line     = 1'b0;
      bus_a.data_enable = 1'b0;
      repeat (3) drive(1'b0, 1'b0, 1'b1, $urandom);
      check("rst_a_out_valid", bus_a.out_valid, 0);
      check("rst_a_frame_done", bus_a.frame_done, 0);
      check("rst_a_frame_count", bus_a.frame_count, 0);
      check("rst_a_out_x", bus_a.out_x, 0);
      check("rst_a_out_y", bus_a.out_y, 0);
      check("rst_a_out_data", bus_a.out_data, 0);
      check("rst_b_out_valid", bus_b.out_valid, 0);
      check("rst_b_frame_done", bus_b.frame_done, 0);
      check("rst_b_frame_count", bus_b.frame_count, 0);
      check("rst_b_out_x", bus_b.out_x, 0);
      check("rst_b_out_y", bus_b.out_y, 0);
      check("rst_b_out_data", bus_b.out_data, 0);
      fc = 0;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic mon_out(input int d, input logic [5:0] x, input logic [4:0] y, input logic [7:0] data);
      logic [50:0] e;
      bit have;
      have = 1'b0;
      e = '0;
      if (d == 0 && exp_q_a.size() > 0) begin e = exp_q_a.pop_front(); have = 1'b1; end
      if (d == 1 && exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); have = 1'b1; end
      if (!have) begin
         checks++;
         failures++;
         $display("FAIL dut%0d_unexpected_strobe actual x=%0d y=%0d data=%0h required=none", d, x, y, data);
      end else begin
         check($sformatf("dut%0d_out_cycle", d), cyc, e[50:19]);
         check($sformatf("dut%0d_out_y", d), y, e[18:14]);
         check($sformatf("dut%0d_out_x", d), x, e[13:8]);
         check($sformatf("dut%0d_out_data", d), data, e[7:0]);
      end
   endtask

   task automatic mon_fd(input int d, input logic [15:0] count);
      logic [47:0] e;
      bit have;
      have = 1'b0;
      e = '0;
      if (d == 0 && fd_q_a.size() > 0) begin e = fd_q_a.pop_front(); have = 1'b1; end
      if (d == 1 && fd_q_b.size() > 0) begin e = fd_q_b.pop_front(); have = 1'b1; end
      if (!have) begin
         checks++;
         failures++;
         $display("FAIL dut%0d_unexpected_frame_done actual count=%0d required=none", d, count);
      end else begin
         check($sformatf("dut%0d_frame_done_cycle", d), cyc, e[47:16]);
         check($sformatf("dut%0d_frame_count", d), count, e[15:0]);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus_a.out_valid)  mon_out(0, bus_a.out_x, bus_a.out_y, bus_a.out_data);
            if (bus_b.out_valid)  mon_out(1, bus_b.out_x, bus_b.out_y, bus_b.out_data);
            if (bus_a.frame_done) mon_fd(0, bus_a.frame_count);
            if (bus_b.frame_done) mon_fd(1, bus_b.frame_count);
         end
      end
   end

   initial begin
      #1_500_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      reset             = 1'b1;
      bus_a.in_frame    = 1'b0;
      bus_a.in_line     = 1'b0;
      bus_a.data_enable = 1'b0;
      bus_a.pixel_data  = '0;
      cur_frame         = 1'b0;
      fc                = 0;
      lidx[0]           = 0;
      lidx[1]           = 0;
      do_reset();

      // Full 512x256 frame of constant 0x80.
      frame_start();
      for (int l = 0; l < 256; l++) begin
         send_line(128, 0, 0, 0);
         idle(2);
      end
      frame_end();

      // Column ramp, 8 lines with gaps; last line closed by in_frame falling.
      frame_start();
      for (int l = 0; l < 7; l++) begin
         send_line(128, 1, 20, 0);
         idle(3);
      end
      send_line(128, 1, 20, 1);
      idle(3);

      // 640-pixel random lines: columns past 63 must stay silent.
      frame_start();
      for (int l = 0; l < 16; l++) begin
         send_line(160, 2, 10, 0);
         idle(2);
      end
      frame_end();

      // Partial bins and random line lengths.
      frame_start();
      send_line(7, 2, 0, 0);
      idle(2);
      for (int l = 0; l < 22; l++) begin
         send_line($urandom_range(1, 140), 2, 15, 0);
         idle($urandom_range(1, 4));
      end
      send_line(50, 2, 0, 1);
      idle(3);

      // Bytes 0x10,0x20,0x30,0x40 back to back.
      frame_start();
      for (int l = 0; l < 8; l++) begin
         send_line(64, 3, 0, 0);
         idle(2);
      end
      frame_end();
      idle(4);
      check_drained("pre_reset");

      // Reset in the middle of a band, then a fresh all-0xFF frame.
      frame_start();
      for (int l = 0; l < 3; l++) begin
         send_line(128, 2, 0, 0);
         idle(1);
      end
      idle(4);
      check_drained("mid_band");
      do_reset();
      idle(3);
      frame_start();
      for (int l = 0; l < 16; l++) begin
         send_line(128, 4, 0, 0);
         idle(2);
      end
      frame_end();

      idle(6);
      check_drained("final");
      check("final_frame_count_a", bus_a.frame_count, 1);
      check("final_frame_count_b", bus_b.frame_count, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
